fd_circle_window: RTL and testbench

//  Upstream feeder for the FAST-9 corner datapath. Accepts a raster-order 8-bit pixel stream, buffers 6 lines,

---
 rtl/fd_pkg.sv | 20 ++
 rtl/fd_line_buffer.sv | 33 +++
 rtl/fd_circle_window.sv | 127 ++++++++++++
 tb/tb_fd_circle_window.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fd_pkg.sv
// Shared types and constants for the FAST-9 circle window feeder.
package fd_pkg;

    typedef logic [7:0] pixel_t;

    localparam int unsigned PIX_W      = 8;
    localparam int unsigned WIN        = 7;
    localparam int unsigned RADIUS     = 3;
    localparam int unsigned NUM_TAPS   = WIN - 1;
    localparam int unsigned NUM_CIRCLE = 16;
    localparam int unsigned ADJ_W      = NUM_CIRCLE * PIX_W;

    localparam int unsigned IMG_W_DEF  = 640;
    localparam int unsigned IMG_H_DEF  = 480;

    // Bresenham radius-3 circle, clockwise from top, y grows downward
    localparam int CIRCLE_DX [NUM_CIRCLE] = '{ 0,  1,  2,  3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
    localparam int CIRCLE_DY [NUM_CIRCLE] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3,  3,  2,  1,  0, -1, -2, -3};

endpackage

// File: rtl/fd_line_buffer.sv
// Six-line pixel history. One wide word per column holds the six previous
// rows of that column; the most recent row sits in the top byte.
module fd_line_buffer
    import fd_pkg::*;
#(
    parameter int unsigned IMG_W = IMG_W_DEF
)(
    input  logic                        clk,
    input  logic                        wr_en,
    input  logic [$clog2(IMG_W)-1:0]    col,
    input  logic [PIX_W-1:0]            din,
    output logic [NUM_TAPS*PIX_W-1:0]   taps
);

    localparam int unsigned WORD_W = NUM_TAPS * PIX_W;

    logic [WORD_W-1:0] mem [IMG_W];
    logic [WORD_W-1:0] rd_word;

    // Read the column before this cycle's write lands (read-before-write)
    always_comb begin
        rd_word = mem[col];
        taps    = rd_word;
    end

    // Push the new pixel in at the top and drop the oldest row off the bottom
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[col] <= {din, rd_word[WORD_W-1:PIX_W]};
        end
    end

endmodule

// File: rtl/fd_circle_window.sv
// FAST-9 feeder: raster pixel stream in, 7x7 window centre plus 16 circle
// pixels out with centre coordinates. Optional macro FD_FRAME_SYNC_EN makes
// an accepted pixel with sof=1 restart the frame counters at (0,0).
module fd_circle_window
    import fd_pkg::*;
#(
    parameter int unsigned IMG_W = IMG_W_DEF,
    parameter int unsigned IMG_H = IMG_H_DEF
)(
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  pixIn,
    input  logic                        inValid,
    output logic                        inReady,
    input  logic                        sof,
    output logic [7:0]                  refPixel,
    output logic [127:0]                adjPixel,
    output logic [$clog2(IMG_W)-1:0]    centreX,
    output logic [$clog2(IMG_H)-1:0]    centreY,
    output logic                        outValid,
    input  logic                        outReady,
    output logic                        frameDone
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(WIN - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(WIN - 1);

    logic [CW-1:0] col, cur_col, col_nxt;
    logic [RW-1:0] row, cur_row, row_nxt;
    logic          accept;
    logic          last_col, last_row;
    logic          centre_ok;

    logic [NUM_TAPS*PIX_W-1:0]          taps;
    logic [WIN-1:0][PIX_W-1:0]          new_col;
    logic [WIN-1:0][WIN-1:0][PIX_W-1:0] win, win_nxt;
    logic [ADJ_W-1:0]                   adj_nxt;

    // Single output register: a new pixel may enter only when the slot drains
    assign inReady = ~outValid | outReady;
    assign accept  = inValid & inReady;

    // Position of the pixel being offered and the counters after it
    always_comb begin
        cur_col = col;
        cur_row = row;
`ifdef FD_FRAME_SYNC_EN
        if (sof) begin
            cur_col = '0;
            cur_row = '0;
        end
`endif
        last_col  = (cur_col == COL_LAST);
        last_row  = (cur_row == ROW_LAST);
        col_nxt   = last_col ? '0 : cur_col + CW'(1);
        row_nxt   = cur_row;
        if (last_col) begin
            row_nxt = last_row ? '0 : cur_row + RW'(1);
        end
        centre_ok = accept && (cur_col >= COL_MIN) && (cur_row >= ROW_MIN);
    end

`ifndef FD_FRAME_SYNC_EN
    logic sof_unused;
    assign sof_unused = sof;
`endif

    fd_line_buffer #(
        .IMG_W (IMG_W)
    ) u_line_buffer (
        .clk   (clk),
        .wr_en (accept),
        .col   (cur_col),
        .din   (pixIn),
        .taps  (taps)
    );

    // Incoming column: current pixel at the bottom, oldest buffered row at the top
    always_comb begin
        new_col = {pixIn, taps};
        win_nxt = {new_col, win[WIN-1:1]};
    end

    // Circle tap mux taken from the window as it will look after this pixel
    for (genvar k = 0; k < NUM_CIRCLE; k++) begin : g_circle
        localparam int XI = int'(RADIUS) + CIRCLE_DX[k];
        localparam int YI = int'(RADIUS) + CIRCLE_DY[k];
        assign adj_nxt[ADJ_W-1-k*PIX_W -: PIX_W] = win_nxt[XI][YI];
    end

    // Counters, window shift, output register and frame pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col       <= '0;
            row       <= '0;
            win       <= '0;
            outValid  <= 1'b0;
            frameDone <= 1'b0;
            refPixel  <= '0;
            adjPixel  <= '0;
            centreX   <= '0;
            centreY   <= '0;
        end else begin
            frameDone <= accept & last_col & last_row;
            if (accept) begin
                col <= col_nxt;
                row <= row_nxt;
                win <= win_nxt;
            end
            if (centre_ok) begin
                outValid <= 1'b1;
                refPixel <= win_nxt[RADIUS][RADIUS];
                adjPixel <= adj_nxt;
                centreX  <= cur_col - CW'(RADIUS);
                centreY  <= cur_row - RW'(RADIUS);
            end else if (outReady) begin
                outValid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fd_circle_window.sv
// Scoreboard bench for fd_circle_window on a 16x16 image, pixel = x + 16*y.
module tb_fd_circle_window;

    localparam int W = 16;
    localparam int H = 16;
    localparam int DX [16] = '{ 0,  1,  2,  3, 3, 3, 2, 1, 0, -1, -2, -3, -3, -3, -2, -1};
    localparam int DY [16] = '{-3, -3, -2, -1, 0, 1, 2, 3, 3,  3,  2,  1,  0, -1, -2, -3};

    typedef struct packed {
        logic [3:0]   x;
        logic [3:0]   y;
        logic [7:0]   refp;
        logic [127:0] adj;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [7:0]   pixIn = '0;
    logic         inValid = 1'b0;
    logic         inReady;
    logic         sof = 1'b0;
    logic [7:0]   refPixel;
    logic [127:0] adjPixel;
    logic [3:0]   centreX;
    logic [3:0]   centreY;
    logic         outValid;
    logic         outReady = 1'b1;
    logic         frameDone;

    exp_t sb_q [$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n_out = 0;
    int   n_fd  = 0;
    int   cap_idx = -1;
    bit   fd_arm = 1'b0;
    bit   fd_q = 1'b0;
    bit   fd_exp;
    logic [7:0]   cap_ref;
    logic [127:0] cap_adj;
    logic [3:0]   cap_x, cap_y;

    fd_circle_window #(.IMG_W(W), .IMG_H(H)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pixIn     (pixIn),
        .inValid   (inValid),
        .inReady   (inReady),
        .sof       (sof),
        .refPixel  (refPixel),
        .adjPixel  (adjPixel),
        .centreX   (centreX),
        .centreY   (centreY),
        .outValid  (outValid),
        .outReady  (outReady),
        .frameDone (frameDone)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] px(input int x, input int y);
        return 8'(x + 16 * y);
    endfunction

    function automatic exp_t make_exp(input int cx, input int cy);
        exp_t e;
        e.x    = 4'(cx);
        e.y    = 4'(cy);
        e.refp = px(cx, cy);
        e.adj  = '0;
        for (int k = 0; k < 16; k++) e.adj[127-8*k -: 8] = px(cx + DX[k], cy + DY[k]);
        return e;
    endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic finish_now();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    endtask

    // Monitor: pops one expectation per transfer and tracks frameDone
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            fd_q   = 1'b0;
            fd_arm = 1'b0;
        end else begin
            fd_exp = fd_q;
            fd_q   = fd_arm;
            fd_arm = 1'b0;
            if (frameDone) n_fd++;
            if (frameDone || fd_exp) chk("frameDone", 128'(frameDone), 128'(fd_exp));
            if (outValid && outReady) begin
                n_cmp++;
                if (sb_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_output: got centre (%0d,%0d) want no output", centreX, centreY);
                end else begin
                    mon_e = sb_q.pop_front();
                    n_out++;
                    if ({centreX, centreY, refPixel, adjPixel} !== mon_e) begin
                        n_err++;
                        $display("FAIL output: got x=%0d y=%0d ref=%h adj=%h want x=%0d y=%0d ref=%h adj=%h",
                                 centreX, centreY, refPixel, adjPixel, mon_e.x, mon_e.y, mon_e.refp, mon_e.adj);
                    end
                    if (n_out == cap_idx) begin
                        cap_ref = refPixel;
                        cap_adj = adjPixel;
                        cap_x   = centreX;
                        cap_y   = centreY;
                    end
                end
            end
        end
    end

    task automatic drive_pixel(input int x, input int y, input bit sofv, input bit bubbles);
        bit acc;
        int guard;
        acc   = 1'b0;
        guard = 0;
        while (!acc) begin
            @(negedge clk);
            inValid = bubbles ? ($urandom_range(0, 2) != 0) : 1'b1;
            pixIn   = px(x, y);
            sof     = sofv;
            #1;
            acc = inValid && inReady;
            guard++;
            if (!acc && guard > 50) begin
                n_cmp++;
                n_err++;
                $display("FAIL accept_timeout: got inReady=%0b want accept of (%0d,%0d)", inReady, x, y);
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
                $fatal(1, "accept timeout");
            end
        end
        if (x >= 6 && y >= 6) sb_q.push_back(make_exp(x - 3, y - 3));
        if (x == W - 1 && y == H - 1) fd_arm = 1'b1;
    endtask

    task automatic do_stall();
        logic [7:0]   s_ref;
        logic [127:0] s_adj;
        logic [3:0]   s_x, s_y;
        @(negedge clk);
        outReady = 1'b0;
        inValid  = 1'b1;
        #1;
        s_ref = refPixel;
        s_adj = adjPixel;
        s_x   = centreX;
        s_y   = centreY;
        chk("stall_valid", 128'(outValid), 128'(1));
        chk("stall_inready", 128'(inReady), 128'(0));
        repeat (4) begin
            @(negedge clk);
            #1;
            chk("stall_inready", 128'(inReady), 128'(0));
            chk("stall_hold", {8'(s_x), 8'(s_y), s_ref, 104'(0)} ^ 128'(s_adj),
                {8'(centreX), 8'(centreY), refPixel, 104'(0)} ^ 128'(adjPixel));
        end
        @(negedge clk);
        inValid  = 1'b0;
        outReady = 1'b1;
    endtask

    task automatic stream_frame(input bit bubbles, input int stall_x, input int stall_y, input bit sof_first);
        for (int y = 0; y < H; y++) begin
            for (int x = 0; x < W; x++) begin
                if (x == stall_x && y == stall_y) do_stall();
                drive_pixel(x, y, sof_first && x == 0 && y == 0, bubbles);
            end
        end
    endtask

    task automatic drain(input string name, input int base, input int want);
        int guard;
        @(negedge clk);
        inValid = 1'b0;
        sof     = 1'b0;
        guard   = 0;
        while (sb_q.size() != 0 && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        repeat (3) @(negedge clk);
        chk({name, "_pending"}, 128'(sb_q.size()), 128'(0));
        chk({name, "_count"}, 128'(n_out - base), 128'(want));
    endtask

    initial begin : main
        int base;
        int fd_base;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        chk("rst_outValid", 128'(outValid), 128'(0));
        chk("rst_frameDone", 128'(frameDone), 128'(0));
        chk("rst_refPixel", 128'(refPixel), 128'(0));
        chk("rst_adjPixel", adjPixel, 128'(0));
        chk("rst_centre", {120'(0), centreX, centreY}, 128'(0));
        chk("rst_inReady", 128'(inReady), 128'(1));
        @(negedge clk);
        rst_n = 1'b1;

        // 1: full frame, consumer always ready
        base    = n_out;
        fd_base = n_fd;
        cap_idx = base + 1;
        stream_frame(1'b0, -1, -1, 1'b0);
        drain("t1", base, 100);
        chk("t1_first_x", 128'(cap_x), 128'(3));
        chk("t1_first_y", 128'(cap_y), 128'(3));
        chk("t1_first_ref", 128'(cap_ref), 128'(8'h33));
        chk("t1_slot0", 128'(cap_adj[127 -: 8]), 128'(8'h03));
        chk("t1_slot4", 128'(cap_adj[95 -: 8]), 128'(8'h36));
        chk("t1_slot8", 128'(cap_adj[63 -: 8]), 128'(8'h63));
        chk("t1_slot12", 128'(cap_adj[31 -: 8]), 128'(8'h30));
        chk("t1_fd_pulses", 128'(n_fd - fd_base), 128'(1));

        // 2: consumer stalls mid-row
        base = n_out;
        stream_frame(1'b0, 10, 8, 1'b0);
        drain("t2", base, 100);

        // 3: random input bubbles
        base = n_out;
        stream_frame(1'b1, -1, -1, 1'b0);
        drain("t3", base, 100);

        // 4: two frames back-to-back
        base    = n_out;
        fd_base = n_fd;
        cap_idx = base + 101;
        stream_frame(1'b0, -1, -1, 1'b0);
        stream_frame(1'b0, -1, -1, 1'b0);
        drain("t4", base, 200);
        chk("t4_f2_first_x", 128'(cap_x), 128'(3));
        chk("t4_f2_first_y", 128'(cap_y), 128'(3));
        chk("t4_f2_first_ref", 128'(cap_ref), 128'(8'h33));
        chk("t4_fd_pulses", 128'(n_fd - fd_base), 128'(2));

        // 5: reset after pixel (7,9), then a clean frame
        for (int y = 0; y <= 9; y++) begin
            for (int x = 0; x < W; x++) begin
                if (y == 9 && x > 7) break;
                drive_pixel(x, y, 1'b0, 1'b0);
            end
        end
        @(negedge clk);
        inValid = 1'b0;
        #1;
        chk("t5_pre_reset_valid", 128'(outValid), 128'(1));
        rst_n = 1'b0;
        #1;
        chk("t5_reset_valid", 128'(outValid), 128'(0));
        chk("t5_reset_centre", {120'(0), centreX, centreY}, 128'(0));
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        base = n_out;
        stream_frame(1'b0, -1, -1, 1'b0);
        drain("t5", base, 100);

`ifdef FD_FRAME_SYNC_EN
        // 6: sof at count (5,2) restarts the frame
        for (int y = 0; y <= 2; y++) begin
            for (int x = 0; x < W; x++) begin
                if (y == 2 && x > 4) break;
                drive_pixel(x, y, 1'b0, 1'b0);
            end
        end
        base = n_out;
        stream_frame(1'b0, -1, -1, 1'b1);
        drain("t6", base, 100);
`endif

        finish_now();
    end

    initial begin : watchdog
        #500000;
        n_cmp++;
        n_err++;
        $display("FAIL watchdog: got no completion want completion before time limit");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

endmodule
